// File: rtl/pmp_csr_check_pkg.sv
// Shared encodings, CSR map and config-byte layout for the PMP CSR/check block.
package pmp_csr_check_pkg;

  localparam int unsigned MAX_ENTRIES  = 16;
  localparam int unsigned NUM_CFG_REGS = 4;
  localparam int unsigned CFG_W        = 8;
  localparam int unsigned CSR_W        = 32;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  localparam logic [7:0] CSR_OP_WRITE = 8'd31;
  localparam logic [7:0] CSR_OP_READ  = 8'd32;
  localparam logic [7:0] CSR_OP_SET   = 8'd33;
  localparam logic [7:0] CSR_OP_CLEAR = 8'd34;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  localparam logic [2:0] ACC_LOAD  = 3'b001;
  localparam logic [2:0] ACC_STORE = 3'b010;
  localparam logic [2:0] ACC_FETCH = 3'b100;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  // Reserved bits [6:5] are never stored.
  localparam logic [CFG_W-1:0] CFG_WMASK = 8'h9F;

  // Read-modify-write result of a CSR op; read and unknown ops keep the old value.
  function automatic logic [CSR_W-1:0] csr_apply(input logic [7:0]       op,
                                                 input logic [CSR_W-1:0] old_v,
                                                 input logic [CSR_W-1:0] wdata);
    logic [CSR_W-1:0] res;
    res = old_v;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old_v | wdata;
      CSR_OP_CLEAR: res = old_v & ~wdata;
      default:      res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pmp_csr_check_if.sv
// CSR access bus plus the address-check request/response of the PMP block.
interface pmp_csr_check_if #(
  parameter int unsigned PLEN = 34
) ();
  logic [31:0]     csr_wdata_i;
  logic [11:0]     csr_addr_i;
  logic [7:0]      csr_op_i;
  logic [PLEN-1:0] addr_i;
  logic [2:0]      access_type_i;
  logic [1:0]      priv_lvl_i;
  logic            allow_o;

  modport master (
    output csr_wdata_i, csr_addr_i, csr_op_i, addr_i, access_type_i, priv_lvl_i,
    input  allow_o
  );

  modport slave (
    input  csr_wdata_i, csr_addr_i, csr_op_i, addr_i, access_type_i, priv_lvl_i,
    output allow_o
  );
endinterface

// File: rtl/pmp_entry.sv
// Address match of a single PMP entry for the OFF/TOR/NA4/NAPOT modes.
module pmp_entry
  import pmp_csr_check_pkg::*;
#(
  parameter int unsigned PLEN    = 34,
  parameter int unsigned PMP_LEN = 32
) (
  input  logic [PLEN-1:0]    addr_i,
  input  pmp_a_e             a_i,
  input  logic [PMP_LEN-1:0] pmpaddr_i,
  input  logic [PMP_LEN-1:0] pmpaddr_prev_i,
  output logic               match_o
);

  localparam int unsigned W = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

  logic [W-1:0]       addr_w;
  logic [W-1:0]       top_w;
  logic [W-1:0]       base_w;
  logic [W-1:0]       low_mask;
  logic [PMP_LEN-1:0] trail;

  // Byte-address compare; trail holds the trailing ones plus the first zero of pmpaddr.
  always_comb begin
    addr_w   = W'(addr_i);
    top_w    = W'({pmpaddr_i, 2'b00});
    base_w   = W'({pmpaddr_prev_i, 2'b00});
    trail    = pmpaddr_i ^ (pmpaddr_i + PMP_LEN'(1));
    low_mask = (&pmpaddr_i) ? '1 : W'({trail, 2'b11});
    match_o  = 1'b0;
    case (a_i)
      A_TOR:   match_o = (base_w < top_w) && (addr_w >= base_w) && (addr_w < top_w);
      A_NA4:   match_o = ((addr_w & ~W'(3)) == top_w);
      A_NAPOT: match_o = (((addr_w ^ top_w) & ~low_mask) == '0);
      default: match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_csr_check.sv
// PMP configuration/address CSRs with a combinational physical-address permission check.
module pmp_csr_check
  import pmp_csr_check_pkg::*;
#(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  pmp_csr_check_if.slave                pmp_if,
  output logic [MAX_ENTRIES*CFG_W-1:0]  pmpcfg_o,
  output logic [MAX_ENTRIES*PMP_LEN-1:0] pmpaddr_o
);

  pmp_cfg_t           cfg_q     [MAX_ENTRIES];
  pmp_cfg_t           cfg_d     [MAX_ENTRIES];
  logic [PMP_LEN-1:0] addr_q    [MAX_ENTRIES];
  logic [PMP_LEN-1:0] addr_d    [MAX_ENTRIES];
  logic [PMP_LEN-1:0] prev_addr [MAX_ENTRIES];
  logic [MAX_ENTRIES:0]   tor_lock;
  logic [MAX_ENTRIES-1:0] match;
  logic [CSR_W-1:0]       cfg_word;
  logic [CSR_W-1:0]       cfg_new;
  logic                   acc_ok;
  logic                   perm;
  logic                   allow_c;

  // CSR next-state: cfg bytes and pmpaddr honour lock bits and the active-entry count.
  always_comb begin
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    cfg_word = '0;
    cfg_new  = '0;
    tor_lock = '0;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      tor_lock[i] = cfg_q[i].l && (cfg_q[i].a == A_TOR);
    end
    for (int unsigned w = 0; w < NUM_CFG_REGS; w++) begin
      if (pmp_if.csr_addr_i == CSR_PMPCFG0 + 12'(w)) begin
        for (int unsigned k = 0; k < 4; k++) begin
          cfg_word[CFG_W*k +: CFG_W] = cfg_q[4*w+k];
        end
        cfg_new = csr_apply(pmp_if.csr_op_i, cfg_word, pmp_if.csr_wdata_i);
        for (int unsigned k = 0; k < 4; k++) begin
          if ((4*w + k) < NR_ENTRIES && !cfg_q[4*w+k].l) begin
            cfg_d[4*w+k] = pmp_cfg_t'(cfg_new[CFG_W*k +: CFG_W] & CFG_WMASK);
          end
        end
      end
    end
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      if (pmp_if.csr_addr_i == CSR_PMPADDR0 + 12'(i) && i < NR_ENTRIES &&
          !cfg_q[i].l && !tor_lock[i+1]) begin
        addr_d[i] = PMP_LEN'(csr_apply(pmp_if.csr_op_i, CSR_W'(addr_q[i]),
                                       pmp_if.csr_wdata_i));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    pmpcfg_o     = '0;
    pmpaddr_o    = '0;
    prev_addr[0] = '0;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      pmpcfg_o[CFG_W*i +: CFG_W]       = cfg_q[i];
      pmpaddr_o[PMP_LEN*i +: PMP_LEN]  = addr_q[i];
    end
    for (int unsigned i = 1; i < MAX_ENTRIES; i++) begin
      prev_addr[i] = addr_q[i-1];
    end
  end

  for (genvar g = 0; g < MAX_ENTRIES; g++) begin : g_entry
    if (g < NR_ENTRIES) begin : g_on
      pmp_entry #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
      ) u_entry (
        .addr_i         (pmp_if.addr_i),
        .a_i            (cfg_q[g].a),
        .pmpaddr_i      (addr_q[g]),
        .pmpaddr_prev_i (prev_addr[g]),
        .match_o        (match[g])
      );
    end else begin : g_off
      assign match[g] = 1'b0;
    end
  end

  // Walk entries high to low so the lowest-indexed match has the final say.
  always_comb begin
    acc_ok  = (pmp_if.access_type_i == ACC_LOAD)  ||
              (pmp_if.access_type_i == ACC_STORE) ||
              (pmp_if.access_type_i == ACC_FETCH);
    perm    = 1'b0;
    allow_c = (pmp_if.priv_lvl_i == PRIV_M);
    for (int e = int'(MAX_ENTRIES) - 1; e >= 0; e--) begin
      if (match[e]) begin
        perm    = acc_ok && |(pmp_if.access_type_i & {cfg_q[e].x, cfg_q[e].w, cfg_q[e].r});
        allow_c = ((pmp_if.priv_lvl_i == PRIV_M) && !cfg_q[e].l) || perm;
      end
    end
  end

  assign pmp_if.allow_o = (NR_ENTRIES == 0) ? 1'b1 : allow_c;

endmodule

// File: tb/tb_pmp_csr_check.sv
// Scenario-driven bench for pmp_csr_check with a queue of expected allow_o results.
module tb_pmp_csr_check;
  import pmp_csr_check_pkg::*;

  localparam int unsigned PLEN    = 34;
  localparam int unsigned PMP_LEN = 32;
  localparam int unsigned NR      = 4;

  typedef struct {
    logic [PLEN-1:0] a;
    logic [2:0]      t;
    logic [1:0]      p;
    logic            e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [127:0]           pmpcfg;
  logic [16*PMP_LEN-1:0]  pmpaddr;
  logic sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pmp_csr_check_if #(.PLEN(PLEN)) pmp_if ();

  pmp_csr_check #(
    .PLEN       (PLEN),
    .PMP_LEN    (PMP_LEN),
    .NR_ENTRIES (NR)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pmp_if    (pmp_if),
    .pmpcfg_o  (pmpcfg),
    .pmpaddr_o (pmpaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [PLEN-1:0] a, input logic [2:0] t,
                              input logic [1:0] p, input logic e);
    vec_t v;
    v.a = a; v.t = t; v.p = p; v.e = e;
    return v;
  endfunction

  task automatic drive_probe(input vec_t v);
    pmp_if.addr_i        = v.a;
    pmp_if.access_type_i = v.t;
    pmp_if.priv_lvl_i    = v.p;
    sb_q.push_back(v.e);
  endtask

  task automatic csr(input logic [7:0] op, input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pmp_if.csr_op_i    = op;
    pmp_if.csr_addr_i  = a;
    pmp_if.csr_wdata_i = d;
    @(posedge clk); #1;
    pmp_if.csr_op_i    = 8'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    pmp_if.csr_op_i    = CSR_OP_WRITE;
    pmp_if.csr_addr_i  = CSR_PMPADDR0;
    pmp_if.csr_wdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    pmp_if.csr_op_i = 8'd0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic exp;
    do_reset();
    n_cmp++;
    if (pmpcfg !== 128'h0) begin
      n_err++; $display("FAIL reset_cfg got=%h want=0", pmpcfg);
    end
    n_cmp++;
    if (pmpaddr !== '0) begin
      n_err++; $display("FAIL reset_addr got=%h want=0", pmpaddr);
    end
    v.push_back(mk(34'h0, ACC_LOAD, PRIV_U, 1'b0));
    v.push_back(mk(34'h0, ACC_LOAD, PRIV_M, 1'b1));
    v.push_back(mk(34'h3FFFFFFFC, ACC_FETCH, PRIV_S, 1'b0));
    v.push_back(mk(34'h123456780, ACC_STORE, PRIV_M, 1'b1));
    for (int i = 0; i < 4; i++) begin
      v.push_back(mk({2'($urandom_range(0, 3)), $urandom}, ACC_LOAD, PRIV_U, 1'b0));
      v.push_back(mk({2'($urandom_range(0, 3)), $urandom}, ACC_FETCH, PRIV_M, 1'b1));
    end
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL reset[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
  endtask

  task automatic test_tor();
    vec_t v[$];
    logic exp;
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h0000000F);
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h20000001);
    n_cmp++;
    if (pmpaddr[31:0] !== 32'h20000001) begin
      n_err++; $display("FAIL tor_addr got=%h want=20000001", pmpaddr[31:0]);
    end
    v.push_back(mk(34'h080000000, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h080000004, ACC_LOAD, PRIV_U, 1'b0));
    v.push_back(mk(34'h000000000, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h07FFFFFFC, ACC_STORE, PRIV_S, 1'b1));
    v.push_back(mk(34'h080000004, ACC_LOAD, PRIV_M, 1'b1));
    v.push_back(mk(34'h000001000, 3'b000, PRIV_U, 1'b0));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL tor[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
  endtask

  task automatic test_napot();
    vec_t v[$];
    logic exp;
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00000019);
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h200001FF);
    v.push_back(mk(34'h080000FFC, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h080000FFC, ACC_STORE, PRIV_U, 1'b0));
    v.push_back(mk(34'h080001000, ACC_LOAD, PRIV_U, 1'b0));
    v.push_back(mk(34'h080000000, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h07FFFFFFC, ACC_LOAD, PRIV_U, 1'b0));
    v.push_back(mk(34'h080000010, ACC_FETCH, PRIV_U, 1'b0));
    v.push_back(mk(34'h080000010, 3'b011, PRIV_U, 1'b0));
    v.push_back(mk(34'h080000FFC, ACC_STORE, PRIV_M, 1'b1));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL napot[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
    // All-ones pmpaddr covers the whole physical space.
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'hFFFFFFFF);
    v.delete();
    v.push_back(mk(34'h000000000, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h3FFFFFFFC, ACC_LOAD, PRIV_S, 1'b1));
    v.push_back(mk({2'($urandom_range(0, 3)), $urandom}, ACC_STORE, PRIV_U, 1'b0));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL napot_all[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
  endtask

  task automatic test_na4();
    vec_t v[$];
    logic exp;
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00000013);
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h00000040);
    v.push_back(mk(34'h000000100, ACC_STORE, PRIV_U, 1'b1));
    v.push_back(mk(34'h000000103, ACC_STORE, PRIV_U, 1'b1));
    v.push_back(mk(34'h000000104, ACC_STORE, PRIV_U, 1'b0));
    v.push_back(mk(34'h0000000FC, ACC_LOAD, PRIV_U, 1'b0));
    v.push_back(mk(34'h000000100, ACC_FETCH, PRIV_U, 1'b0));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL na4[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
  endtask

  task automatic test_lock();
    vec_t v[$];
    logic exp;
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h20000001);
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00000089);
    v.push_back(mk(34'h000000100, ACC_STORE, PRIV_M, 1'b0));
    v.push_back(mk(34'h000000100, ACC_LOAD, PRIV_M, 1'b1));
    v.push_back(mk(34'h000000100, ACC_FETCH, PRIV_M, 1'b0));
    v.push_back(mk(34'h080000004, ACC_STORE, PRIV_M, 1'b1));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL lock[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00001F0F);
    n_cmp++;
    if (pmpcfg[15:0] !== 16'h1F89) begin
      n_err++; $display("FAIL lock_cfg got=%h want=1f89", pmpcfg[15:0]);
    end
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h00001234);
    n_cmp++;
    if (pmpaddr[31:0] !== 32'h20000001) begin
      n_err++; $display("FAIL lock_addr got=%h want=20000001", pmpaddr[31:0]);
    end
  endtask

  task automatic test_tor_lock();
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h00000100);
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00008F00);
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h00000200);
    csr(CSR_OP_WRITE, CSR_PMPADDR0 + 12'd1, 32'h00000300);
    n_cmp++;
    if (pmpaddr[63:0] !== 64'h0000000000000100) begin
      n_err++; $display("FAIL torlock_addr got=%h want=0000000000000100", pmpaddr[63:0]);
    end
    csr(CSR_OP_SET, CSR_PMPCFG0, 32'h00000001);
    n_cmp++;
    if (pmpcfg[31:0] !== 32'h00008F01) begin
      n_err++; $display("FAIL torlock_set got=%h want=00008f01", pmpcfg[31:0]);
    end
    csr(CSR_OP_CLEAR, CSR_PMPCFG0, 32'h0000FF01);
    n_cmp++;
    if (pmpcfg[31:0] !== 32'h00008F00) begin
      n_err++; $display("FAIL torlock_clr got=%h want=00008f00", pmpcfg[31:0]);
    end
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h007F0000);
    n_cmp++;
    if (pmpcfg[31:0] !== 32'h001F8F00) begin
      n_err++; $display("FAIL torlock_rsvd got=%h want=001f8f00", pmpcfg[31:0]);
    end
  endtask

  task automatic test_priority();
    vec_t v[$];
    logic exp;
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPADDR0, 32'h00000100);
    csr(CSR_OP_WRITE, CSR_PMPADDR0 + 12'd1, 32'h000001FF);
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00001909);
    v.push_back(mk(34'h000000200, ACC_STORE, PRIV_U, 1'b0));
    v.push_back(mk(34'h000000400, ACC_LOAD, PRIV_U, 1'b1));
    v.push_back(mk(34'h000000400, ACC_STORE, PRIV_U, 1'b0));
    v.push_back(mk(34'h000001000, ACC_LOAD, PRIV_U, 1'b0));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL prio[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
    // Entry1 now grants RWX, but entry0 still wins inside its own range.
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h00001F09);
    v.delete();
    v.push_back(mk(34'h000000200, ACC_STORE, PRIV_U, 1'b0));
    v.push_back(mk(34'h000000400, ACC_STORE, PRIV_U, 1'b1));
    v.push_back(mk(34'h0000003FC, ACC_FETCH, PRIV_S, 1'b0));
    foreach (v[i]) begin
      drive_probe(v[i]);
      @(negedge clk);
      exp = sb_q.pop_front();
      n_cmp++;
      if (pmp_if.allow_o !== exp) begin
        n_err++;
        $display("FAIL prio2[%0d] addr=%h allow=%b want=%b", i, v[i].a, pmp_if.allow_o, exp);
      end
    end
  endtask

  task automatic test_csr_ops();
    logic [31:0] want [6];
    want = '{32'h0000F0F0, 32'h0F00F0FF, 32'h0F00F00F, 32'h0F00F00F, 32'h0F00F00F, 32'h0F00F00F};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: csr(CSR_OP_WRITE, CSR_PMPADDR0 + 12'd2, 32'h0000F0F0);
        1: csr(CSR_OP_SET,   CSR_PMPADDR0 + 12'd2, 32'h0F00000F);
        2: csr(CSR_OP_CLEAR, CSR_PMPADDR0 + 12'd2, 32'h000000F0);
        3: csr(CSR_OP_READ,  CSR_PMPADDR0 + 12'd2, 32'hFFFFFFFF);
        4: csr(8'd35,        CSR_PMPADDR0 + 12'd2, 32'h12345678);
        default: csr(CSR_OP_WRITE, 12'h3C2, 32'hFFFFFFFF);
      endcase
      n_cmp++;
      if (pmpaddr[95:64] !== want[i]) begin
        n_err++; $display("FAIL csrop[%0d] got=%h want=%h", i, pmpaddr[95:64], want[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    csr(CSR_OP_WRITE, CSR_PMPADDR0 + 12'd5, 32'hFFFFFFFF);
    csr(CSR_OP_WRITE, CSR_PMPCFG0 + 12'd1, 32'h0F0F0F0F);
    csr(CSR_OP_WRITE, CSR_PMPADDR0 + 12'd3, 32'h0000ABCD);
    csr(CSR_OP_WRITE, CSR_PMPCFG0, 32'h0F0F0F0F);
    n_cmp++;
    if (pmpaddr[191:160] !== 32'h0) begin
      n_err++; $display("FAIL oor_addr5 got=%h want=0", pmpaddr[191:160]);
    end
    n_cmp++;
    if (pmpcfg[127:32] !== 96'h0) begin
      n_err++; $display("FAIL oor_cfg got=%h want=0", pmpcfg[127:32]);
    end
    n_cmp++;
    if (pmpaddr[127:96] !== 32'h0000ABCD) begin
      n_err++; $display("FAIL oor_addr3 got=%h want=0000abcd", pmpaddr[127:96]);
    end
    n_cmp++;
    if (pmpcfg[31:0] !== 32'h0F0F0F0F) begin
      n_err++; $display("FAIL oor_cfg0 got=%h want=0f0f0f0f", pmpcfg[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      pmp_if.csr_op_i    = CSR_OP_WRITE;
      pmp_if.csr_addr_i  = CSR_PMPADDR0 + 12'(i);
      pmp_if.csr_wdata_i = vals[i];
      @(posedge clk); #1;
    end
    pmp_if.csr_op_i = 8'd0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pmpaddr[32*i +: 32] !== vals[i]) begin
        n_err++; $display("FAIL b2b[%0d] got=%h want=%h", i, pmpaddr[32*i +: 32], vals[i]);
      end
    end
  endtask

  initial begin
    rst                  = 1'b1;
    pmp_if.csr_op_i      = 8'd0;
    pmp_if.csr_addr_i    = 12'h0;
    pmp_if.csr_wdata_i   = 32'h0;
    pmp_if.addr_i        = '0;
    pmp_if.access_type_i = ACC_LOAD;
    pmp_if.priv_lvl_i    = PRIV_M;
    test_reset();
    test_tor();
    test_napot();
    test_na4();
    test_lock();
    test_tor_lock();
    test_priority();
    test_csr_ops();
    test_out_of_range();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
